// File: rtl/pu_msp430_ram_arb_pkg.sv
// Shared types for the MSP430 data-RAM arbiter: port ids, read-enable code, return-stage record.
// Types only; no logic, no latency, no flow control.
package pu_msp430_ram_arb_pkg;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    localparam logic [1:0] WEN_READ = 2'b11;

    typedef struct packed {
        logic  valid;
        port_e owner;
        logic  oob;
    } ret_s;

endpackage

// File: rtl/pu_msp430_ram_arb_sel.sv
// Winner select for the two RAM masters plus the round-robin pointer; grant is 0-cycle combinational.
// A losing port is simply not granted and keeps its request up; no grants while reset is asserted.
module pu_msp430_ram_arb_sel
    import pu_msp430_ram_arb_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic  mclk,
    input  logic  puc_rst_n,
    input  logic  a_req,
    input  logic  b_req,
    output logic  a_gnt,
    output logic  b_gnt,
    output port_e win
);

    port_e last_q;
    port_e last_d;

    always_comb begin
        a_gnt  = 1'b0;
        b_gnt  = 1'b0;
        win    = PORT_A;
        last_d = last_q;
        if (puc_rst_n) begin
            // Under contention A wins if it has priority or B was served last.
            if (a_req && (!b_req || FIXED_PRIO != 0 || last_q == PORT_B)) begin
                a_gnt = 1'b1;
            end else if (b_req) begin
                b_gnt = 1'b1;
            end
        end
        if (b_gnt) begin
            win = PORT_B;
        end
        if (a_gnt || b_gnt) begin
            last_d = win;
        end
    end

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            last_q <= PORT_B;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/pu_msp430_ram_arbiter.sv
// Shares one single-port data RAM between CPU (A) and DMA/debug (B); grant in cycle N, read data in N+1.
// One access per cycle; the loser holds its request; out-of-range accesses are granted but blocked and flagged.
module pu_msp430_ram_arbiter
    import pu_msp430_ram_arb_pkg::*;
#(
    parameter int ADDR_MSB   = 6,
    parameter int MEM_SIZE   = 256,
    parameter int FIXED_PRIO = 0
) (
    input  logic                mclk,
    input  logic                puc_rst_n,
    input  logic                a_req,
    input  logic [ADDR_MSB:0]   a_addr,
    input  logic [1:0]          a_wen,
    input  logic [15:0]         a_din,
    output logic                a_gnt,
    output logic [15:0]         a_dout,
    output logic                a_rvld,
    input  logic                b_req,
    input  logic [ADDR_MSB:0]   b_addr,
    input  logic [1:0]          b_wen,
    input  logic [15:0]         b_din,
    output logic                b_gnt,
    output logic [15:0]         b_dout,
    output logic                b_rvld,
    output logic                ram_cen,
    output logic [ADDR_MSB:0]   ram_addr,
    output logic [15:0]         ram_din,
    output logic [1:0]          ram_wen,
    input  logic [15:0]         ram_dout,
    output logic                err_oob
);

    localparam int AW = ADDR_MSB + 1;
    localparam logic [AW:0] WORDS = (AW + 1)'(MEM_SIZE / 2);

    port_e           win;
    logic            gnt_any;
    logic            oob;
    logic [AW-1:0]   sel_addr;
    logic [1:0]      sel_wen;
    logic [15:0]     sel_din;
    logic [15:0]     rdata;

    logic [AW-1:0]   ram_addr_q, ram_addr_d;
    logic [15:0]     ram_din_q, ram_din_d;
    ret_s            ret_q, ret_d;
    logic            err_oob_q, err_oob_d;
    logic [15:0]     a_hold_q, a_hold_d;
    logic [15:0]     b_hold_q, b_hold_d;

    pu_msp430_ram_arb_sel #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_sel (
        .mclk      (mclk),
        .puc_rst_n (puc_rst_n),
        .a_req     (a_req),
        .b_req     (b_req),
        .a_gnt     (a_gnt),
        .b_gnt     (b_gnt),
        .win       (win)
    );

    assign gnt_any  = a_gnt | b_gnt;
    assign sel_addr = (win == PORT_B) ? b_addr : a_addr;
    assign sel_wen  = (win == PORT_B) ? b_wen  : a_wen;
    assign sel_din  = (win == PORT_B) ? b_din  : a_din;
    assign oob      = {1'b0, sel_addr} >= WORDS;

    always_comb begin
        ram_cen    = 1'b1;
        ram_wen    = WEN_READ;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        // Address/data lines only move on a real RAM access to avoid needless toggling.
        if (gnt_any && !oob) begin
            ram_cen    = 1'b0;
            ram_wen    = sel_wen;
            ram_addr_d = sel_addr;
            ram_din_d  = sel_din;
        end

        ret_d.valid = gnt_any && (sel_wen == WEN_READ);
        ret_d.owner = win;
        ret_d.oob   = oob;
        err_oob_d   = gnt_any && oob;

        a_rvld = ret_q.valid && (ret_q.owner == PORT_A);
        b_rvld = ret_q.valid && (ret_q.owner == PORT_B);
        rdata  = ret_q.oob ? 16'h0000 : ram_dout;
        a_dout = a_rvld ? rdata : a_hold_q;
        b_dout = b_rvld ? rdata : b_hold_q;
        a_hold_d = a_dout;
        b_hold_d = b_dout;
    end

    assign ram_addr = ram_addr_d;
    assign ram_din  = ram_din_d;
    assign err_oob  = err_oob_q;

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            ret_q      <= '{valid: 1'b0, owner: PORT_A, oob: 1'b0};
            err_oob_q  <= 1'b0;
            a_hold_q   <= '0;
            b_hold_q   <= '0;
        end else begin
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            ret_q      <= ret_d;
            err_oob_q  <= err_oob_d;
            a_hold_q   <= a_hold_d;
            b_hold_q   <= b_hold_d;
        end
    end

endmodule

// File: tb/tb_pu_msp430_ram_arbiter.sv
// Bench: instance 0 round-robin, instance 1 fixed priority, both MEM_SIZE=64 (32 words) against a
// behavioural RAM macro and a transaction-level reference model with its own golden memory.
module tb_pu_msp430_ram_arbiter;

    logic        mclk = 1'b0;
    logic        puc_rst_n = 1'b0;
    logic        a_req [2];
    logic [6:0]  a_addr [2];
    logic [1:0]  a_wen [2];
    logic [15:0] a_din [2];
    logic        a_gnt [2];
    logic [15:0] a_dout [2];
    logic        a_rvld [2];
    logic        b_req [2];
    logic [6:0]  b_addr [2];
    logic [1:0]  b_wen [2];
    logic [15:0] b_din [2];
    logic        b_gnt [2];
    logic [15:0] b_dout [2];
    logic        b_rvld [2];
    logic        ram_cen [2];
    logic [6:0]  ram_addr [2];
    logic [15:0] ram_din [2];
    logic [1:0]  ram_wen [2];
    logic [15:0] ram_dout [2];
    logic        err_oob [2];

    always #5 mclk = ~mclk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        pu_msp430_ram_arbiter #(
            .ADDR_MSB   (6),
            .MEM_SIZE   (64),
            .FIXED_PRIO (g)
        ) u_dut (
            .mclk      (mclk),
            .puc_rst_n (puc_rst_n),
            .a_req     (a_req[g]),
            .a_addr    (a_addr[g]),
            .a_wen     (a_wen[g]),
            .a_din     (a_din[g]),
            .a_gnt     (a_gnt[g]),
            .a_dout    (a_dout[g]),
            .a_rvld    (a_rvld[g]),
            .b_req     (b_req[g]),
            .b_addr    (b_addr[g]),
            .b_wen     (b_wen[g]),
            .b_din     (b_din[g]),
            .b_gnt     (b_gnt[g]),
            .b_dout    (b_dout[g]),
            .b_rvld    (b_rvld[g]),
            .ram_cen   (ram_cen[g]),
            .ram_addr  (ram_addr[g]),
            .ram_din   (ram_din[g]),
            .ram_wen   (ram_wen[g]),
            .ram_dout  (ram_dout[g]),
            .err_oob   (err_oob[g])
        );
    end

    function automatic logic [15:0] init_word(int i);
        if (i == 5) return 16'hBEEF;
        if (i == 3) return 16'h5566;
        return 16'hA000 ^ (16'(i) * 16'h0137);
    endfunction

    // RAM macro: synchronous single port, dout updated on enabled reads only.
    logic [15:0] ram_mem [2][32];
    logic        ram_init_done = 1'b0;
    always @(posedge mclk) begin
        for (int k = 0; k < 2; k++) begin
            if (!ram_init_done) begin
                for (int i = 0; i < 32; i++) ram_mem[k][i] <= init_word(i);
            end else if (!ram_cen[k]) begin
                if (ram_wen[k] == 2'b11) begin
                    ram_dout[k] <= ram_mem[k][ram_addr[k][4:0]];
                end else begin
                    if (!ram_wen[k][0]) ram_mem[k][ram_addr[k][4:0]][7:0]  <= ram_din[k][7:0];
                    if (!ram_wen[k][1]) ram_mem[k][ram_addr[k][4:0]][15:8] <= ram_din[k][15:8];
                end
            end
        end
        ram_init_done <= 1'b1;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state (per instance)
    logic [15:0] gold [2][32];
    bit          last_b [2];
    logic [6:0]  prv_addr [2];
    logic [15:0] prv_din [2];
    bit          pend_a [2], pend_b [2], pend_err [2];
    logic [15:0] pend_dat [2];
    logic [15:0] hold_a [2], hold_b [2];
    int          m_w [2];
    logic [6:0]  m_addr [2];
    logic [1:0]  m_wen [2];
    logic [15:0] m_din [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            last_b[k] = 1'b1; prv_addr[k] = '0; prv_din[k] = '0;
            pend_a[k] = 1'b0; pend_b[k] = 1'b0; pend_err[k] = 1'b0; pend_dat[k] = '0;
            hold_a[k] = '0; hold_b[k] = '0; m_w[k] = 0;
        end
    endtask

    task automatic check_inst(input int k);
        string s;
        bit inr;
        s = $sformatf("u%0d", k);
        if (!puc_rst_n) begin
            m_w[k] = 0;
            check({s, ".rst_a_gnt"}, 32'(a_gnt[k]), 0);
            check({s, ".rst_b_gnt"}, 32'(b_gnt[k]), 0);
            check({s, ".rst_cen"},   32'(ram_cen[k]), 1);
            check({s, ".rst_wen"},   32'(ram_wen[k]), 3);
            check({s, ".rst_addr"},  32'(ram_addr[k]), 0);
            check({s, ".rst_din"},   32'(ram_din[k]), 0);
            check({s, ".rst_a_dout"}, 32'(a_dout[k]), 0);
            check({s, ".rst_b_dout"}, 32'(b_dout[k]), 0);
            check({s, ".rst_rvld"},  32'({a_rvld[k], b_rvld[k]}), 0);
            check({s, ".rst_err"},   32'(err_oob[k]), 0);
            return;
        end
        m_w[k] = 0;
        if (a_req[k] && (!b_req[k] || k == 1 || last_b[k])) m_w[k] = 1;
        else if (b_req[k]) m_w[k] = 2;
        m_addr[k] = (m_w[k] == 2) ? b_addr[k] : a_addr[k];
        m_wen[k]  = (m_w[k] == 2) ? b_wen[k]  : a_wen[k];
        m_din[k]  = (m_w[k] == 2) ? b_din[k]  : a_din[k];
        inr = (m_w[k] != 0) && (m_addr[k] < 7'd32);
        check({s, ".a_gnt"},    32'(a_gnt[k]), 32'(m_w[k] == 1));
        check({s, ".b_gnt"},    32'(b_gnt[k]), 32'(m_w[k] == 2));
        check({s, ".ram_cen"},  32'(ram_cen[k]), 32'(!inr));
        check({s, ".ram_wen"},  32'(ram_wen[k]), inr ? 32'(m_wen[k]) : 32'd3);
        check({s, ".ram_addr"}, 32'(ram_addr[k]), inr ? 32'(m_addr[k]) : 32'(prv_addr[k]));
        check({s, ".ram_din"},  32'(ram_din[k]), inr ? 32'(m_din[k]) : 32'(prv_din[k]));
        check({s, ".a_rvld"},   32'(a_rvld[k]), 32'(pend_a[k]));
        check({s, ".b_rvld"},   32'(b_rvld[k]), 32'(pend_b[k]));
        check({s, ".a_dout"},   32'(a_dout[k]), pend_a[k] ? 32'(pend_dat[k]) : 32'(hold_a[k]));
        check({s, ".b_dout"},   32'(b_dout[k]), pend_b[k] ? 32'(pend_dat[k]) : 32'(hold_b[k]));
        check({s, ".err_oob"},  32'(err_oob[k]), 32'(pend_err[k]));
    endtask

    task automatic update_inst(input int k);
        bit oob;
        int wa;
        if (!puc_rst_n) begin
            last_b[k] = 1'b1; prv_addr[k] = '0; prv_din[k] = '0;
            pend_a[k] = 1'b0; pend_b[k] = 1'b0; pend_err[k] = 1'b0;
            hold_a[k] = '0; hold_b[k] = '0; m_w[k] = 0;
            return;
        end
        if (pend_a[k]) hold_a[k] = pend_dat[k];
        if (pend_b[k]) hold_b[k] = pend_dat[k];
        pend_a[k] = 1'b0; pend_b[k] = 1'b0; pend_err[k] = 1'b0;
        if (m_w[k] != 0) begin
            last_b[k]   = (m_w[k] == 2);
            oob         = m_addr[k] >= 7'd32;
            pend_err[k] = oob;
            wa          = int'(m_addr[k]) % 32;
            if (m_wen[k] == 2'b11) begin
                pend_a[k]   = (m_w[k] == 1);
                pend_b[k]   = (m_w[k] == 2);
                pend_dat[k] = oob ? 16'h0000 : gold[k][wa];
            end else if (!oob) begin
                if (!m_wen[k][0]) gold[k][wa][7:0]  = m_din[k][7:0];
                if (!m_wen[k][1]) gold[k][wa][15:8] = m_din[k][15:8];
            end
            if (!oob) begin
                prv_addr[k] = m_addr[k];
                prv_din[k]  = m_din[k];
            end
        end
    endtask

    // One clock: check at negedge, optionally drop reset before the edge, update model at posedge.
    task automatic step(input bit drop_rst = 1'b0);
        @(negedge mclk);
        for (int k = 0; k < 2; k++) check_inst(k);
        if (drop_rst) begin
            #1 puc_rst_n = 1'b0;
        end
        @(posedge mclk);
        for (int k = 0; k < 2; k++) update_inst(k);
        #1;
    endtask

    task automatic set_a(input logic req, input logic [6:0] addr, input logic [1:0] wen, input logic [15:0] din);
        for (int k = 0; k < 2; k++) begin
            a_req[k] = req; a_addr[k] = addr; a_wen[k] = wen; a_din[k] = din;
        end
    endtask

    task automatic set_b(input logic req, input logic [6:0] addr, input logic [1:0] wen, input logic [15:0] din);
        for (int k = 0; k < 2; k++) begin
            b_req[k] = req; b_addr[k] = addr; b_wen[k] = wen; b_din[k] = din;
        end
    endtask

    task automatic rand_req(output logic req, output logic [6:0] addr, output logic [1:0] wen, output logic [15:0] din);
        logic [1:0] wtab [5];
        wtab = '{2'b11, 2'b11, 2'b00, 2'b01, 2'b10};
        req  = ($urandom_range(0, 3) != 0);
        addr = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(32, 127)) : 7'($urandom_range(0, 7));
        wen  = wtab[$urandom_range(0, 4)];
        din  = 16'($urandom);
    endtask

    initial begin
        for (int k = 0; k < 32; k++) begin
            gold[0][k] = init_word(k);
            gold[1][k] = init_word(k);
        end
        model_reset();
        set_a(1'b0, '0, 2'b11, '0);
        set_b(1'b0, '0, 2'b11, '0);
        repeat (3) step();
        puc_rst_n = 1'b1;
        step();

        // Contention with both ports reading: RR alternates starting with A, fixed prio keeps A.
        set_a(1'b1, 7'd1, 2'b11, '0);
        set_b(1'b1, 7'd2, 2'b11, '0);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_a_gnt", 32'(a_gnt[0]), 32'(i % 2 == 0));
            check("fp_b_gnt", 32'(b_gnt[1]), 0);
            step();
        end
        set_a(1'b0, '0, 2'b11, '0);
        set_b(1'b0, '0, 2'b11, '0);
        step();

        // A-only read of preloaded address 5.
        set_a(1'b1, 7'd5, 2'b11, '0);
        step();
        set_a(1'b0, '0, 2'b11, '0);
        check("beef_rvld", 32'(a_rvld[0]), 1);
        check("beef_dout", 32'(a_dout[0]), 32'h0000BEEF);
        step();
        check("beef_hold", 32'(a_dout[0]), 32'h0000BEEF);

        // Low-byte write by B, then A reads it back.
        set_b(1'b1, 7'd3, 2'b10, 16'h12AB);
        step();
        set_b(1'b0, '0, 2'b11, '0);
        set_a(1'b1, 7'd3, 2'b11, '0);
        step();
        set_a(1'b0, '0, 2'b11, '0);
        check("bytewr_dout", 32'(a_dout[0]), 32'h000055AB);
        step();

        // Out-of-range read.
        set_a(1'b1, 7'd127, 2'b11, '0);
        #1;
        check("oob_cen", 32'(ram_cen[0]), 1);
        step();
        set_a(1'b0, '0, 2'b11, '0);
        check("oob_err", 32'(err_oob[0]), 1);
        check("oob_rvld", 32'(a_rvld[0]), 1);
        check("oob_dout", 32'(a_dout[0]), 0);
        step();

        // Reset dropped in the middle of a granted B read.
        set_b(1'b1, 7'd7, 2'b11, '0);
        step(1'b1);
        set_b(1'b0, '0, 2'b11, '0);
        check("rst_no_rvld", 32'(b_rvld[0]), 0);
        step();
        puc_rst_n = 1'b1;
        step();
        step();

        // Randomised traffic; a port keeps its request until granted.
        for (int c = 0; c < 2000; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!a_req[k] || m_w[k] == 1) rand_req(a_req[k], a_addr[k], a_wen[k], a_din[k]);
                if (!b_req[k] || m_w[k] == 2) rand_req(b_req[k], b_addr[k], b_wen[k], b_din[k]);
            end
            step();
        end
        set_a(1'b0, '0, 2'b11, '0);
        set_b(1'b0, '0, 2'b11, '0);
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
